// File: rtl/hamming_serial_secded_decoder_pkg.sv
// Shared Hamming helpers (position mapping, syndrome) for the serial decoder and the planned encoder.
package hamming_pkg;
    localparam int M_DEF = 3;
    localparam int N_DEF = (1 << M_DEF) - 1;
    localparam int K_DEF = N_DEF - M_DEF;
    localparam int MAX_M = 6;
    localparam int MAX_N = (1 << MAX_M) - 1;

    function automatic logic is_pow2(input int p);
        return (p > 0) && ((p & (p - 1)) == 0);
    endfunction

    // Data index k lives at the k-th codeword position that is not a power of two.
    function automatic int data_pos(input int k);
        int cnt;
        int pos;
        cnt = 0;
        pos = 0;
        for (int p = 1; p <= MAX_N; p++) begin
            if (!is_pow2(p)) begin
                if (cnt == k && pos == 0) pos = p;
                cnt++;
            end
        end
        return pos;
    endfunction

    // Bit 0 of cw is position 1; unused upper positions must be zero.
    function automatic logic [MAX_M-1:0] calc_syndrome(input logic [MAX_N-1:0] cw);
        logic [MAX_M-1:0] s;
        s = '0;
        for (int p = 1; p <= MAX_N; p++)
            if (cw[p-1]) s ^= MAX_M'(p);
        return s;
    endfunction
endpackage

// File: rtl/hamming_serial_secded_decoder_corrector.sv
// Combinational syndrome/correction stage; HAMMING_SECDED_EN adds the overall-parity bit at the top of cw.
module hamming_syndrome_corrector
    import hamming_pkg::*;
#(
    parameter int M = 3,
    localparam int N = (1 << M) - 1,
    localparam int K = N - M,
`ifdef HAMMING_SECDED_EN
    localparam int NB = N + 1
`else
    localparam int NB = N
`endif
) (
    input  logic [NB-1:0] cw,
    output logic [K-1:0]  data,
    output logic [M-1:0]  syndrome,
    output logic          err_corr,
    output logic          err_uncorr
);
    logic [N-1:0] fixed;
    logic         flip;
`ifdef HAMMING_SECDED_EN
    logic         par_bad;
`endif

    always_comb begin
        syndrome = M'(calc_syndrome(MAX_N'(cw[N-1:0])));
`ifdef HAMMING_SECDED_EN
        // Odd overall parity means an odd number of flips; a clean parity with a syndrome means two.
        par_bad    = ^cw;
        flip       = par_bad && (syndrome != '0);
        err_corr   = par_bad;
        err_uncorr = !par_bad && (syndrome != '0);
`else
        flip       = (syndrome != '0);
        err_corr   = flip;
        err_uncorr = 1'b0;
`endif
        fixed = cw[N-1:0];
        if (flip) fixed[syndrome - M'(1)] = ~fixed[syndrome - M'(1)];
        data = '0;
        for (int k = 0; k < K; k++) data[k] = fixed[data_pos(k) - 1];
    end
endmodule

// File: rtl/hamming_serial_secded_decoder.sv
// Serial-in Hamming(2^M-1) decoder with valid/ready in and out; HAMMING_SECDED_EN selects SECDED mode.
module hamming_serial_secded_decoder
    import hamming_pkg::*;
#(
    parameter int M     = 3,
    parameter int CNT_W = 16,
    localparam int N = (1 << M) - 1,
    localparam int K = N - M
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             frame_sync,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [K-1:0]     data_out,
    output logic [M-1:0]     syndrome,
    output logic             err_corr,
    output logic             err_uncorr,
    output logic [CNT_W-1:0] corr_cnt
);
`ifdef HAMMING_SECDED_EN
    localparam int NB = N + 1;
`else
    localparam int NB = N;
`endif
    localparam int CW = $clog2(NB);

    localparam logic [0:0] COLLECT = 1'b0;
    localparam logic [0:0] DECODE  = 1'b1;

    logic [0:0]    state;
    logic [CW-1:0] cnt;
    logic [NB-1:0] cw_buf;
    logic [K-1:0]  dec_data;
    logic [M-1:0]  dec_syn;
    logic          dec_corr, dec_uncorr;
    logic          accept, load;

    assign in_ready = ena && (state == COLLECT);
    assign accept   = in_valid && in_ready;
    assign load     = ena && (state == DECODE) && (!out_valid || out_ready);

    hamming_syndrome_corrector #(.M(M)) u_corr (
        .cw         (cw_buf),
        .data       (dec_data),
        .syndrome   (dec_syn),
        .err_corr   (dec_corr),
        .err_uncorr (dec_uncorr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= COLLECT;
            cnt    <= '0;
            cw_buf <= '0;
        end else if (ena) begin
            if (state == COLLECT) begin
                if (accept) begin
                    // A resync bit is position 1 of the new word.
                    if (frame_sync) begin
                        cw_buf[0] <= in_bit;
                        cnt       <= CW'(1);
                    end else begin
                        cw_buf[cnt] <= in_bit;
                        if (cnt == CW'(NB - 1)) state <= DECODE;
                        else                    cnt   <= cnt + CW'(1);
                    end
                end else if (frame_sync) begin
                    cnt <= '0;
                end
            end else if (load) begin
                state <= COLLECT;
                cnt   <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            data_out   <= '0;
            syndrome   <= '0;
            err_corr   <= 1'b0;
            err_uncorr <= 1'b0;
            corr_cnt   <= '0;
        end else if (load) begin
            out_valid  <= 1'b1;
            data_out   <= dec_data;
            syndrome   <= dec_syn;
            err_corr   <= dec_corr;
            err_uncorr <= dec_uncorr;
            if (dec_corr && (corr_cnt != '1)) corr_cnt <= corr_cnt + CNT_W'(1);
        end else if (ena && out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_hamming_serial_secded_decoder.sv
// Scoreboard bench for the serial Hamming decoder (M=3, 2-bit counter to reach saturation).
module tb_hamming_serial_secded_decoder;
    localparam int M = 3, N = 7, K = 4, CNT_W = 2;
`ifdef HAMMING_SECDED_EN
    localparam int NB = N + 1;
    localparam bit SECDED = 1'b1;
`else
    localparam int NB = N;
    localparam bit SECDED = 1'b0;
`endif
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [K-1:0] data;
        logic [M-1:0] syn;
        logic         corr;
        logic         uncorr;
    } exp_t;

    logic clk = 1'b0, rst_n = 1'b0, ena = 1'b0, frame_sync = 1'b0;
    logic in_valid = 1'b0, in_bit = 1'b0, out_ready = 1'b0;
    logic in_ready, out_valid, err_corr, err_uncorr;
    logic [K-1:0] data_out;
    logic [M-1:0] syndrome;
    logic [CNT_W-1:0] corr_cnt;

    exp_t sb[$];
    int checks = 0, failures = 0, exp_cnt = 0;

    always #5 clk = ~clk;

    hamming_serial_secded_decoder #(.M(M), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .frame_sync(frame_sync),
        .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
        .syndrome(syndrome), .err_corr(err_corr), .err_uncorr(err_uncorr),
        .corr_cnt(corr_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            check("sb_nonempty", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                if (e.corr && exp_cnt < CNT_MAX) exp_cnt++;
                check("data_out", data_out, e.data);
                check("syndrome", syndrome, e.syn);
                check("err_corr", err_corr, e.corr);
                check("err_uncorr", err_uncorr, e.uncorr);
                check("corr_cnt", corr_cnt, exp_cnt);
            end
        end
    end

    function automatic logic [NB-1:0] encode(input logic [K-1:0] d);
        logic [NB-1:0] cw;
        int k;
        cw = '0;
        k = 0;
        for (int p = 1; p <= N; p++)
            if ((p & (p - 1)) != 0) begin cw[p-1] = d[k]; k++; end
        for (int i = 0; i < M; i++) begin
            logic par;
            par = 1'b0;
            for (int p = 1; p <= N; p++)
                if (((p >> i) & 1) == 1 && p != (1 << i)) par ^= cw[p-1];
            cw[(1 << i) - 1] = par;
        end
        if (SECDED) cw[NB-1] = ^cw[N-1:0];
        return cw;
    endfunction

    task automatic push_exp(input logic [K-1:0] d, input logic [M-1:0] s, input logic c, input logic u);
        exp_t e;
        e.data = d; e.syn = s; e.corr = c; e.uncorr = u;
        sb.push_back(e);
    endtask

    task automatic send_bit(input logic b, input logic fs);
        int n;
        n = 0;
        in_valid = 1'b1; in_bit = b; frame_sync = fs;
        @(negedge clk);
        while (!in_ready && n < 200) begin n++; @(negedge clk); end
        if (n >= 200) check("in_ready_timeout", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; frame_sync = 1'b0;
    endtask

    task automatic send_cw(input logic [NB-1:0] cw, input logic fs_first);
        for (int i = 0; i < NB; i++) send_bit(cw[i], fs_first && i == 0);
    endtask

    // f = flipped position (0 = clean); single flips are always correctable here.
    task automatic send_word(input logic [K-1:0] d, input int f, input logic fs_first);
        logic [NB-1:0] cw;
        cw = encode(d);
        if (f != 0) cw[f-1] = ~cw[f-1];
        push_exp(d, (f >= 1 && f <= N) ? M'(f) : '0, f != 0, 1'b0);
        send_cw(cw, fs_first);
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
        check(tag, out_valid, 1);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin @(posedge clk); #1; n++; end
        check(tag, sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NB-1:0] cw;
        logic [K-1:0] d1, d;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_data_out", data_out, 0);
        check("rst_syndrome", syndrome, 0);
        check("rst_err_corr", err_corr, 0);
        check("rst_err_uncorr", err_uncorr, 0);
        check("rst_corr_cnt", corr_cnt, 0);
        rst_n = 1'b1; ena = 1'b1; out_ready = 1'b1;
        #1 check("in_ready_idle", in_ready, 1);

        // Clean spec word plus t+2 latency.
        push_exp(4'b1011, 3'd0, 1'b0, 1'b0);
        cw = NB'(7'b1010101);
        send_cw(cw, 1'b0);
        check("lat_t1", out_valid, 0);
        @(posedge clk); #1;
        check("lat_t2", out_valid, 1);
        drain("drain_clean");

        // p6 flipped.
        push_exp(4'b1011, 3'd6, 1'b1, 1'b0);
        cw = NB'(7'b1110101);
        send_cw(cw, 1'b0);
        drain("drain_p6");
        check("cnt_after_p6", corr_cnt, 1);

`ifdef HAMMING_SECDED_EN
        push_exp(4'b1001, 3'd7, 1'b0, 1'b1);
        cw = 8'b0100_0111;
        send_cw(cw, 1'b0);
        drain("drain_double");
        check("cnt_after_double", corr_cnt, 1);
`endif

        for (int i = 0; i < 6; i++)
            send_word(K'($urandom_range(0, 15)), $urandom_range(0, NB), 1'b0);
        for (int i = 0; i < 3; i++)
            send_word(K'($urandom_range(0, 15)), i + 1, 1'b0);
        drain("drain_random");
        check("cnt_saturated", corr_cnt, CNT_MAX);

        // Backpressure: word 1 held, word 2 stalls in decode, word 3 follows.
        out_ready = 1'b0;
        d1 = K'($urandom_range(0, 15));
        send_word(d1, 0, 1'b0);
        wait_valid("stall_w1_valid");
        send_word(K'($urandom_range(0, 15)), 3, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("stall_hold", data_out, d1);
            check("stall_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        send_word(K'($urandom_range(0, 15)), 5, 1'b0);
        drain("drain_stall");

        // Resync after a 3-bit fragment.
        for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
        send_word(K'($urandom_range(0, 15)), 0, 1'b1);
        drain("drain_fsync");

        // ena low mid-word: bits offered while disabled must be ignored.
        d = K'($urandom_range(0, 15));
        cw = encode(d);
        push_exp(d, 3'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) send_bit(cw[i], 1'b0);
        ena = 1'b0; in_valid = 1'b1; in_bit = ~cw[3];
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("ena_low_ready", in_ready, 0);
        end
        in_valid = 1'b0; ena = 1'b1;
        for (int i = 3; i < NB; i++) send_bit(cw[i], 1'b0);
        drain("drain_ena");

        // Reset with a held output and a partial word in flight.
        out_ready = 1'b0;
        send_word(K'($urandom_range(0, 15)), 2, 1'b0);
        wait_valid("rst_w_valid");
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        sb.delete();
        exp_cnt = 0;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_data_out", data_out, 0);
        check("mid_rst_syndrome", syndrome, 0);
        check("mid_rst_err_corr", err_corr, 0);
        check("mid_rst_corr_cnt", corr_cnt, 0);
        @(posedge clk); #1;
        rst_n = 1'b1; out_ready = 1'b1;
        send_word(K'($urandom_range(0, 15)), 4, 1'b0);
        drain("drain_post_rst");
        check("post_rst_cnt", corr_cnt, 1);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
